palette_bank_fader: RTL and testbench

Programmable, multi-bank colour palette for the sprite pipeline. Sprite ROMs store only colour indices. This block maps a (bank, index) pair to RGB through a register-file palette that software/FSM logic can rewrite at run time. It also applies a frame-paced fade-to-black or flash-to-white effect, used for boss hit flashes and screen transitions. It sits between the sprite index fetch and the VGA colour mux.

---
 rtl/palette_pkg.sv | 24 ++
 rtl/palette_bank_fader_fade_channel.sv | 24 ++
 rtl/palette_bank_fader.sv | 150 +++++++++++++++
 tb/tb_palette_bank_fader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types for the sprite palette / fader: fade FSM states, fade direction and packed RGB.
package palette_pkg;

  localparam int PAL_CH_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

  typedef enum logic {
    FADE_BLACK = 1'b0,
    FADE_WHITE = 1'b1
  } fade_mode_t;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/palette_bank_fader_fade_channel.sv
// One colour channel pushed toward black (saturating subtract) or white (saturating add) by level_i.
module fade_channel
  import palette_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0] c_i,
  input  logic [CH_W-1:0] level_i,
  input  fade_mode_t      mode_i,
  output logic [CH_W-1:0] y_o
);

  logic [CH_W:0] sum;

  always_comb begin
    sum = {1'b0, c_i} + {1'b0, level_i};
    if (mode_i == FADE_WHITE) begin
      y_o = sum[CH_W] ? '1 : sum[CH_W-1:0];
    end else begin
      y_o = (c_i > level_i) ? (c_i - level_i) : '0;
    end
  end

endmodule

// File: rtl/palette_bank_fader.sv
// Multi-bank flop palette mapping (bank, index) to RGB, with a frame-paced fade to black/white.
module palette_bank_fader
  import palette_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 4,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [IDX_W-1:0]  index,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              frame_tick,
  input  logic              fade_start,
  input  logic              fade_mode,
  input  logic              fade_release,
  output logic [CH_W-1:0]   fade_level,
  output logic              fade_busy,
  output logic              fade_done
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CH_W-1:0] MAX = '1;

  logic [3*CH_W-1:0] pal_q [NUM_BANKS][DEPTH];
  logic [BANK_W-1:0] rd_bank;
  logic [3*CH_W-1:0] rd_entry;
  logic [CH_W-1:0]   fade_r, fade_g, fade_b;

  fade_state_t       state_q, state_d;
  fade_mode_t        mode_q, mode_d;
  logic [CH_W-1:0]   level_q, level_d;
  logic              pend_q, pend_d;
  logic              done_d;

  // Palette resets to a grey ramp so unprogrammed sprites are still visible.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          pal_q[b][i] <= {3{CH_W'(i)}};
        end
      end
    end else if (wr_en && (int'(wr_bank) < NUM_BANKS)) begin
      pal_q[wr_bank][wr_idx] <= wr_rgb;
    end
  end

  always_comb begin
    rd_bank  = (int'(bank_sel) < NUM_BANKS) ? bank_sel : '0;
    rd_entry = pal_q[rd_bank][index];
  end

  fade_channel #(.CH_W(CH_W)) u_fade_r (
    .c_i(rd_entry[3*CH_W-1 -: CH_W]), .level_i(level_q), .mode_i(mode_q), .y_o(fade_r));
  fade_channel #(.CH_W(CH_W)) u_fade_g (
    .c_i(rd_entry[2*CH_W-1 -: CH_W]), .level_i(level_q), .mode_i(mode_q), .y_o(fade_g));
  fade_channel #(.CH_W(CH_W)) u_fade_b (
    .c_i(rd_entry[CH_W-1 -: CH_W]), .level_i(level_q), .mode_i(mode_q), .y_o(fade_b));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      red         <= fade_r;
      green       <= fade_g;
      blue        <= fade_b;
      transparent <= (index == '0);
    end
  end

  // state     | meaning
  // IDLE      | no effect, level 0
  // RAMP_UP   | +1 per frame_tick until MAX; early release is remembered
  // HOLD      | level MAX until release
  // RAMP_DOWN | -1 per frame_tick until 0, then fade_done
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      mode_q    <= FADE_BLACK;
      level_q   <= '0;
      pend_q    <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      pend_q    <= pend_d;
      fade_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    level_d = level_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = '0;
        if (fade_start) begin
          state_d = RAMP_UP;
          mode_d  = fade_mode_t'(fade_mode);
          pend_d  = 1'b0;
        end
      end
      RAMP_UP: begin
        if (fade_release) pend_d = 1'b1;
        if (frame_tick) begin
          level_d = level_q + CH_W'(1);
          if (level_d == MAX) state_d = HOLD;
        end
      end
      HOLD: begin
        level_d = MAX;
        if (pend_q || fade_release) begin
          state_d = RAMP_DOWN;
          pend_d  = 1'b0;
        end
      end
      RAMP_DOWN: begin
        if (frame_tick) begin
          level_d = level_q - CH_W'(1);
          if (level_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fade_level = level_q;
  assign fade_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_palette_bank_fader.sv
// Directed bench for palette_bank_fader: behavioural palette/fade model checked every cycle plus literal pins.
module tb_palette_bank_fader;
  import palette_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  bank_sel, wr_bank;
  logic [3:0]  index, wr_idx;
  logic [11:0] wr_rgb;
  logic        wr_en, frame_tick, fade_start, fade_mode, fade_release;
  logic [3:0]  red, green, blue, fade_level;
  logic        transparent, fade_busy, fade_done;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  // model state
  int pal [4][16][3];
  int lvl, ph, md, pend;
  int e_rgb [3];
  int e_tr, e_done;

  palette_bank_fader dut (
    .Clk(Clk), .Reset(Reset), .bank_sel(bank_sel), .index(index),
    .red(red), .green(green), .blue(blue), .transparent(transparent),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .frame_tick(frame_tick), .fade_start(fade_start), .fade_mode(fade_mode),
    .fade_release(fade_release), .fade_level(fade_level), .fade_busy(fade_busy),
    .fade_done(fade_done));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 16; i++)
        for (int c = 0; c < 3; c++) pal[b][i][c] = i;
    lvl = 0; ph = 0; md = 0; pend = 0;
    for (int c = 0; c < 3; c++) e_rgb[c] = 0;
    e_tr = 0; e_done = 0;
  endtask

  // ph: 0 idle, 1 rising, 2 held at 15, 3 falling
  task automatic model_step();
    int rb, c, v;
    rgb_t w;
    rb = (int'(bank_sel) < 4) ? int'(bank_sel) : 0;
    for (int k = 0; k < 3; k++) begin
      c = pal[rb][index][k];
      if (md == 1) v = (c + lvl > 15) ? 15 : c + lvl;
      else         v = (c - lvl < 0) ? 0 : c - lvl;
      e_rgb[k] = v;
    end
    e_tr   = (index == 4'd0) ? 1 : 0;
    e_done = 0;
    if (ph == 0) begin
      if (fade_start) begin ph = 1; md = int'(fade_mode); pend = 0; end
    end else if (ph == 1) begin
      if (fade_release) pend = 1;
      if (frame_tick) begin lvl = lvl + 1; if (lvl == 15) ph = 2; end
    end else if (ph == 2) begin
      if (pend == 1 || fade_release) begin ph = 3; pend = 0; end
    end else begin
      if (frame_tick) begin
        lvl = lvl - 1;
        if (lvl == 0) begin ph = 0; e_done = 1; end
      end
    end
    if (wr_en && int'(wr_bank) < 4) begin
      w = wr_rgb;
      pal[wr_bank][wr_idx][0] = int'(w.r);
      pal[wr_bank][wr_idx][1] = int'(w.g);
      pal[wr_bank][wr_idx][2] = int'(w.b);
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else model_step();
  end

  always @(negedge Clk) begin
    if (run_chk && !Reset) begin
      chk("m_red", red, e_rgb[0]);
      chk("m_green", green, e_rgb[1]);
      chk("m_blue", blue, e_rgb[2]);
      chk("m_transparent", transparent, e_tr);
      chk("m_level", fade_level, lvl);
      chk("m_busy", fade_busy, (ph != 0) ? 1 : 0);
      chk("m_done", fade_done, e_done);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      wr_en = 1'b0; frame_tick = 1'b0; fade_start = 1'b0; fade_release = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      cyc(1);
    end
  endtask

  task automatic chk_rgb(input string nm, input int r, input int g, input int b);
    chk({nm, "_r"}, red, r);
    chk({nm, "_g"}, green, g);
    chk({nm, "_b"}, blue, b);
  endtask

  initial begin
    bank_sel = '0; index = '0; wr_en = 0; wr_bank = '0; wr_idx = '0; wr_rgb = '0;
    frame_tick = 0; fade_start = 0; fade_mode = 0; fade_release = 0;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk_rgb("reset_rgb", 0, 0, 0);
    chk("reset_transparent", transparent, 0);
    chk("reset_level", fade_level, 0);
    chk("reset_busy", fade_busy, 0);
    chk("reset_done", fade_done, 0);
    Reset = 1'b0;
    run_chk = 1'b1;

    bank_sel = 2; index = 7; cyc(1);
    chk_rgb("grey_b2i7", 7, 7, 7);
    chk("opaque_i7", transparent, 0);
    index = 0; cyc(1);
    chk("transparent_i0", transparent, 1);

    wr_en = 1; wr_bank = 1; wr_idx = 3; wr_rgb = 12'hF81;
    bank_sel = 1; index = 3; cyc(1);
    chk_rgb("wr_same_cycle_old", 3, 3, 3);
    cyc(1);
    chk_rgb("wr_next_cycle_new", 15, 8, 1);
    bank_sel = 0; cyc(1);
    chk_rgb("other_bank_untouched", 3, 3, 3);

    wr_en = 1; wr_bank = 0; wr_idx = 5; wr_rgb = 12'h941; index = 5; cyc(1);
    fade_mode = 0; fade_start = 1; cyc(1);
    ticks(4);
    chk("black_l4_level", fade_level, 4);
    chk_rgb("black_l4", 5, 0, 0);
    ticks(11);
    chk("black_hold_level", fade_level, 15);
    chk("black_hold_busy", fade_busy, 1);
    chk_rgb("black_hold", 0, 0, 0);
    fade_release = 1; cyc(1);
    ticks(14);
    frame_tick = 1; cyc(1);
    chk("black_done_pulse", fade_done, 1);
    chk("black_done_level", fade_level, 0);
    cyc(1);
    chk("black_done_clear", fade_done, 0);
    chk_rgb("black_restored", 9, 4, 1);

    fade_mode = 1; fade_start = 1; cyc(1);
    ticks(8);
    chk_rgb("white_l8", 15, 12, 9);
    ticks(7);
    chk_rgb("white_hold", 15, 15, 15);
    fade_release = 1; cyc(1);
    ticks(14);
    frame_tick = 1; cyc(1);
    chk("white_done_pulse", fade_done, 1);
    cyc(1);
    chk_rgb("white_restored", 9, 4, 1);

    fade_mode = 0; fade_start = 1; frame_tick = 1; cyc(1);
    chk("start_tick_level", fade_level, 0);
    chk("start_tick_busy", fade_busy, 1);
    ticks(3);
    chk("pend_l3", fade_level, 3);
    fade_release = 1; cyc(1);
    fade_mode = 1; fade_start = 1; cyc(1);
    fade_mode = 0;
    ticks(7);
    chk("pend_l10", fade_level, 10);
    chk_rgb("mode_kept_black", 0, 0, 0);
    ticks(5);
    chk("pend_top", fade_level, 15);
    ticks(1);
    chk("pend_tick16", fade_level, 14);
    ticks(13);
    frame_tick = 1; cyc(1);
    chk("pend_done_pulse", fade_done, 1);

    wr_en = 1; wr_bank = 2; wr_idx = 7; wr_rgb = 12'h123; cyc(1);
    fade_mode = 1; fade_start = 1; cyc(1);
    ticks(15);
    fade_release = 1; cyc(1);
    ticks(6);
    chk("abort_l9", fade_level, 9);
    run_chk = 1'b0;
    Reset = 1'b1;
    #1;
    chk_rgb("abort_rgb", 0, 0, 0);
    chk("abort_level", fade_level, 0);
    chk("abort_busy", fade_busy, 0);
    chk("abort_done", fade_done, 0);
    cyc(2);
    chk("abort_done_held", fade_done, 0);
    Reset = 1'b0;
    run_chk = 1'b1;
    bank_sel = 2; index = 7; cyc(1);
    chk_rgb("abort_grey_b2i7", 7, 7, 7);
    bank_sel = 1; index = 3; cyc(1);
    chk_rgb("abort_grey_b1i3", 3, 3, 3);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
